// File: rtl/ifetch_buf.sv
// Fetch buffer: sequential PC, imem req/ack, DEPTH x {pc, instr} queue to decode; IFB_BYPASS_EN adds empty-queue bypass.
// Latency: ack to inst_valid 1 cycle (0 with IFB_BYPASS_EN); redirect to new imem_addr 1 cycle, or 1 after a stale ack.
// Backpressure: fetch parks in IDLE while no slot is free; inst_ready low holds the head entry.
module ifetch_buf #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redir,
   input  logic [31:0] redir_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

   state_t        state, state_next;
   logic [31:0]   fetch_pc, fetch_pc_next;
   logic [31:0]   addr_q;
   logic [31:0]   mem_pc   [DEPTH];
   logic [31:0]   mem_inst [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_next;
   logic          fifo_vld, ack_fetch, bypass, push, pop;

   assign imem_req  = (state != IDLE);
   assign imem_addr = addr_q;

   always_comb begin
      fifo_vld  = (count != '0);
      ack_fetch = (state == FETCH) && imem_ack;
`ifdef IFB_BYPASS_EN
      bypass    = ack_fetch && !fifo_vld && !redir;
`else
      bypass    = 1'b0;
`endif
      inst_valid = fifo_vld || bypass;
      inst_data  = bypass ? imem_rdata : mem_inst[rd_ptr];
      inst_pc    = bypass ? fetch_pc   : mem_pc[rd_ptr];

      // A bypassed word taken by decode in the same cycle never enters the queue.
      pop  = fifo_vld && inst_ready && !redir;
      push = ack_fetch && !redir && !(bypass && inst_ready);
      count_next = redir ? '0 : count + CW'(push) - CW'(pop);

      fetch_pc_next = fetch_pc;
      if (redir)
         fetch_pc_next = {redir_pc[31:2], 2'b00};
      else if (ack_fetch)
         fetch_pc_next = fetch_pc + 32'd4;

      state_next = state;
      case (state)
         IDLE: begin
            if (redir || count_next < CW'(DEPTH))
               state_next = FETCH;
         end
         FETCH: begin
            if (redir)
               state_next = imem_ack ? FETCH : DROP;
            else if (imem_ack)
               state_next = (count_next < CW'(DEPTH)) ? FETCH : IDLE;
         end
         // The stale read must complete before the target can be requested.
         DROP: begin
            if (imem_ack)
               state_next = FETCH;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         addr_q   <= RESET_PC;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc[i]   <= '0;
            mem_inst[i] <= '0;
         end
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
         count    <= count_next;
         if (state_next != DROP)
            addr_q <= fetch_pc_next;
         if (redir) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) begin
               mem_pc[wr_ptr]   <= fetch_pc;
               mem_inst[wr_ptr] <= imem_rdata;
               wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

endmodule

// File: tb/tb_ifetch_buf.sv
// Bench for ifetch_buf: directed scenarios plus a randomized run against an in-order PC stream model.
module tb_ifetch_buf;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFB_BYPASS_EN
   localparam int LAT = 0;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        redir = 1'b0;
   logic [31:0] redir_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int mem_wait = 0;
   bit mem_rand = 1'b0;
   bit mm_busy  = 1'b0;
   int mm_waited = 0;
   int mm_lat    = 0;

   ifetch_buf #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk        (clk),
      .rst        (rst),
      .redir      (redir),
      .redir_pc   (redir_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .inst_valid (inst_valid),
      .inst_data  (inst_data),
      .inst_pc    (inst_pc),
      .inst_ready (inst_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
   endfunction

   // Instruction memory: acks after mm_lat extra request cycles, holding at most one request.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst !== 1'b0 || imem_req !== 1'b1) begin
            mm_busy  = 1'b0;
            imem_ack = 1'b0;
         end else begin
            if (imem_ack || !mm_busy) begin
               mm_busy   = 1'b1;
               mm_waited = 0;
               mm_lat    = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
            end else begin
               mm_waited++;
            end
            imem_ack = (mm_waited >= mm_lat);
         end
         imem_rdata = imem_ack ? mdata(imem_addr) : 32'h0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc;
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset;
      rst = 1'b0; redir = 1'b0; inst_ready = 1'b0; mem_rand = 1'b0; mem_wait = 0;
      #1;
      rst = 1'b1;
      repeat (3) cyc;
      #1;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
      n_checks++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
      n_checks++; if (inst_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", inst_data); end
      n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", inst_pc); end
   endtask

   task automatic test_stream;
      logic [31:0] exp_addr, exp_pc;
      cyc;
      inst_ready = 1'b1;
      rst = 1'b0;
      #1;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stream_release_req: got %b want 0", imem_req); end
      for (int k = 0; k < 5; k++) begin
         cyc;
         #1;
         exp_addr = 32'(4 * k);
         n_checks++;
         if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
            n_fail++; $display("FAIL stream_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, exp_addr);
         end
         if (k < LAT) begin
            n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 0", k, inst_valid); end
         end else begin
            exp_pc = 32'(4 * (k - LAT));
            n_checks++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst_data !== mdata(exp_pc)) begin
               n_fail++; $display("FAIL stream_out[%0d]: got v=%b pc=%h d=%h want v=1 pc=%h d=%h", k, inst_valid, inst_pc, inst_data, exp_pc, mdata(exp_pc));
            end
         end
      end
   endtask

   task automatic test_full;
      logic [31:0] aq[$];
      cyc;
      rst = 1'b1; inst_ready = 1'b0; mem_wait = 0;
      cyc;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc;
         #1;
         if (imem_req && imem_ack) aq.push_back(imem_addr);
      end
      n_checks++;
      if (aq.size() != DEPTH) begin
         n_fail++; $display("FAIL full_push_count: got %0d want %0d", aq.size(), DEPTH);
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (aq[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL full_push_addr[%0d]: got %h want %h", i, aq[i], 32'(4 * i)); end
         end
      end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req_low: got %b want 0", imem_req); end
      n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL full_head: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); end
      cyc;
      inst_ready = 1'b1;
      #1;
      n_checks++; if (inst_pc !== 32'h0 || inst_data !== mdata(32'h0)) begin n_fail++; $display("FAIL full_pop_head: got pc=%h d=%h want pc=0", inst_pc, inst_data); end
      cyc;
      inst_ready = 1'b0;
      #1;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL full_refetch: got req=%b addr=%h want req=1 addr=10", imem_req, imem_addr); end
      n_checks++; if (inst_pc !== 32'h4) begin n_fail++; $display("FAIL full_next_head: got %h want 4", inst_pc); end
   endtask

   task automatic test_redirect;
      bit found;
      cyc;
      mem_wait = 1; redir = 1'b1; redir_pc = 32'h0000_1003; inst_ready = 1'b1;
      cyc;
      redir = 1'b0;
      #1;
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got valid=%b want 0", inst_valid); end
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1000) begin n_fail++; $display("FAIL redir_addr: got req=%b addr=%h want 1000", imem_req, imem_addr); end
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (i > 0) begin cyc; #1; end
         if (inst_valid && inst_ready) begin
            found = 1'b1;
            n_checks++;
            if (inst_pc !== 32'h1000 || inst_data !== mdata(32'h1000)) begin
               n_fail++; $display("FAIL redir_first_pc: got pc=%h d=%h want pc=1000 d=%h", inst_pc, inst_data, mdata(32'h1000));
            end
         end
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL redir_timeout: got no handshake want pc 1000"); end
   endtask

   task automatic test_drop;
      bit found, ack_seen;
      cyc;
      rst = 1'b1; mem_wait = 3; inst_ready = 1'b1;
      cyc;
      rst = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cyc;
         #1;
         if (imem_req && imem_addr == 32'h8) found = 1'b1;
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL drop_wait8: got no request want addr 8"); end
      redir = 1'b1; redir_pc = 32'h0000_2000; mem_wait = 0;
      ack_seen = 1'b0;
      for (int i = 0; i < 10 && !ack_seen; i++) begin
         cyc;
         redir = 1'b0;
         #1;
         n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL drop_hold[%0d]: got req=%b addr=%h want 8", i, imem_req, imem_addr); end
         n_checks++; if (inst_valid && inst_pc == 32'h8) begin n_fail++; $display("FAIL drop_stale_out: got pc=%h want none", inst_pc); end
         if (imem_ack) ack_seen = 1'b1;
      end
      n_checks++; if (!ack_seen) begin n_fail++; $display("FAIL drop_ack_timeout: got no ack want stale ack"); end
      cyc;
      #1;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin n_fail++; $display("FAIL drop_target: got req=%b addr=%h want 2000", imem_req, imem_addr); end
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (i > 0) begin cyc; #1; end
         if (inst_valid && inst_ready) begin
            found = 1'b1;
            n_checks++; if (inst_pc !== 32'h2000) begin n_fail++; $display("FAIL drop_first_pc: got %h want 2000", inst_pc); end
         end
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL drop_hs_timeout: got no handshake want pc 2000"); end
   endtask

   task automatic test_wrap;
      logic [31:0] aq[$];
      logic [31:0] pq[$];
      logic [31:0] dq[$];
      cyc;
      redir = 1'b1; redir_pc = 32'hFFFF_FFFC; inst_ready = 1'b1; mem_wait = 0;
      for (int i = 0; i < 6; i++) begin
         cyc;
         redir = 1'b0;
         #1;
         if (imem_req && imem_ack) aq.push_back(imem_addr);
         if (inst_valid && inst_ready) begin pq.push_back(inst_pc); dq.push_back(inst_data); end
      end
      n_checks++;
      if (aq.size() < 2) begin
         n_fail++; $display("FAIL wrap_acks: got %0d want >=2", aq.size());
      end else if (aq[0] !== 32'hFFFF_FFFC || aq[1] !== 32'h0) begin
         n_fail++; $display("FAIL wrap_addr: got %h,%h want FFFFFFFC,00000000", aq[0], aq[1]);
      end
      n_checks++;
      if (pq.size() < 3) begin
         n_fail++; $display("FAIL wrap_hs: got %0d want >=3", pq.size());
      end else if (pq[0] !== 32'hFFFF_FFFC || pq[1] !== 32'h0 || pq[2] !== 32'h4 || dq[1] !== mdata(32'h0)) begin
         n_fail++; $display("FAIL wrap_pc: got %h,%h,%h want FFFFFFFC,0,4", pq[0], pq[1], pq[2]);
      end
   endtask

   task automatic test_reset_mid;
      bit found;
      cyc;
      mem_wait = 2; inst_ready = 1'b0; redir = 1'b1; redir_pc = 32'h0000_0100;
      cyc;
      redir = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         cyc;
         #1;
         if (imem_req && imem_addr == 32'h10C) found = 1'b1;
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL rmid_wait: got no request want addr 10C"); end
      n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin n_fail++; $display("FAIL rmid_queued: got v=%b pc=%h want v=1 pc=100", inst_valid, inst_pc); end
      rst = 1'b1;
      #1;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_async: got %b want 0", imem_req); end
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid_async: got %b want 0", inst_valid); end
      cyc;
      mem_wait = 0; inst_ready = 1'b1; rst = 1'b0;
      #1;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_release: got %b want 0", imem_req); end
      cyc;
      #1;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin n_fail++; $display("FAIL rmid_restart: got req=%b addr=%h want %h", imem_req, imem_addr, RESET_PC); end
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (i > 0) begin cyc; #1; end
         if (inst_valid && inst_ready) begin
            found = 1'b1;
            n_checks++; if (inst_pc !== RESET_PC || inst_data !== mdata(RESET_PC)) begin n_fail++; $display("FAIL rmid_first_pc: got %h want %h", inst_pc, RESET_PC); end
         end
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL rmid_hs_timeout: got no handshake want pc %h", RESET_PC); end
   endtask

   // Model: after a redirect to T, decode must accept T, T+4, ... in order, each with its memory word.
   task automatic test_random;
      logic [31:0] exp_pc, prev_addr;
      bit          prev_pend;
      int          hs;
      exp_pc = 32'h0; prev_addr = 32'h0; prev_pend = 1'b0; hs = 0;
      mem_rand = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         cyc;
         redir = (i == 0) || ($urandom_range(0, 15) == 0);
         redir_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         inst_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (prev_pend) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
               n_fail++; $display("FAIL rand_req_hold[%0d]: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, prev_addr);
            end
         end
         prev_pend = imem_req && !imem_ack;
         prev_addr = imem_addr;
         if (redir) begin
            exp_pc = {redir_pc[31:2], 2'b00};
         end else if (inst_valid && inst_ready) begin
            hs++;
            n_checks++;
            if (inst_pc !== exp_pc || inst_data !== mdata(exp_pc)) begin
               n_fail++; $display("FAIL rand_stream[%0d]: got pc=%h d=%h want pc=%h d=%h", i, inst_pc, inst_data, exp_pc, mdata(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
         end
      end
      cyc;
      redir = 1'b0;
      mem_rand = 1'b0;
      n_checks++; if (hs < 200) begin n_fail++; $display("FAIL rand_throughput: got %0d handshakes want >=200", hs); end
   endtask

   initial begin
      test_reset;
      test_stream;
      test_full;
      test_redirect;
      test_drop;
      test_wrap;
      test_reset_mid;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
